video_cfg_ctrl: RTL

Command-driven configuration controller for the video/audio output path. It parses the MCU OSD byte stream (start pulse, byte strobe, 8-bit data) into register writes. Settings land in shadow registers and are committed to the scandoubler, HDMI wide-screen and audio-volume controls only at a frame boundary, so a change never tears a frame. It sits in the `clk32_i` domain, between the MCU interface and the video top level.

---
 rtl/video_cfg_pkg.sv | 32 +++
 rtl/video_cfg_ctrl_if.sv | 30 +++
 rtl/video_cfg_parser.sv | 97 +++++++++
 rtl/video_cfg_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/video_cfg_pkg.sv
// -----------------------------------------------------------------------------
// video_cfg_pkg
// Shared types and constants for the video/audio configuration controller:
//   - parser_state_e : OSD byte-stream parser states
//   - OP_*           : opcode bytes
//   - ADDR_*         : register addresses within a WRITE transaction
//   - video_cfg_t    : one full set of output settings (shadow or active)
// -----------------------------------------------------------------------------
package video_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_SKIP
  } parser_state_e;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_COMMIT = 8'h02;

  localparam logic [7:0] ADDR_SCANLINES = 8'd0;
  localparam logic [7:0] ADDR_VOLUME    = 8'd1;
  localparam logic [7:0] ADDR_WIDE      = 8'd2;

  typedef struct packed {
    logic [1:0] scanlines;
    logic [1:0] volume;
    logic       wide;
  } video_cfg_t;

endpackage

// File: rtl/video_cfg_ctrl_if.sv
// -----------------------------------------------------------------------------
// video_cfg_ctrl_if
// Bundles the MCU OSD byte stream, the source vsync and the configuration
// outputs of video_cfg_ctrl.
//   master : MCU / video-source side (drives bytes and vs_n, reads settings)
//   slave  : the controller (reads bytes and vs_n, drives settings)
// -----------------------------------------------------------------------------
interface video_cfg_ctrl_if;

  logic       mcu_start;
  logic       mcu_strobe;
  logic [7:0] mcu_data;
  logic       vs_n;
  logic [1:0] system_scanlines;
  logic [1:0] system_volume;
  logic       system_wide_screen;
  logic       pending;
  logic       cmd_error;

  modport master (
    output mcu_start, mcu_strobe, mcu_data, vs_n,
    input  system_scanlines, system_volume, system_wide_screen, pending, cmd_error
  );

  modport slave (
    input  mcu_start, mcu_strobe, mcu_data, vs_n,
    output system_scanlines, system_volume, system_wide_screen, pending, cmd_error
  );

endinterface

// File: rtl/video_cfg_parser.sv
// -----------------------------------------------------------------------------
// video_cfg_parser
// Decodes the MCU OSD byte stream into register-write and commit strobes.
// A transaction is: start pulse, opcode byte, then for WRITE any number of
// (address, value) byte pairs.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   start_i         : transaction start pulse (may coincide with strobe_i)
//   strobe_i/data_i : byte strobe and byte
//   wr_en_o         : one-cycle shadow write request (address is in range)
//   wr_addr_o       : register address for wr_en_o
//   wr_val_o        : value bits for wr_en_o
//   commit_o        : one-cycle COMMIT_NOW request
//   cmd_error_o     : sticky error, cleared by the next start_i
// -----------------------------------------------------------------------------
module video_cfg_parser
  import video_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       strobe_i,
  input  logic [7:0] data_i,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_o,
  output logic [1:0] wr_val_o,
  output logic       commit_o,
  output logic       cmd_error_o
);

  parser_state_e state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic          err_q, err_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    err_d    = err_q;
    wr_en_o  = 1'b0;
    commit_o = 1'b0;

    if (start_i) begin
      state_d = ST_CMD;
      err_d   = 1'b0;
    end

    if (strobe_i && (start_i || state_q == ST_CMD)) begin
      // A byte arriving with the start pulse is already the opcode.
      case (data_i)
        OP_WRITE:  state_d = ST_ADDR;
        OP_COMMIT: begin
          commit_o = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_SKIP;
          err_d   = 1'b1;
        end
      endcase
    end else if (strobe_i && !start_i) begin
      case (state_q)
        ST_ADDR: begin
          addr_d  = data_i;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          // Out-of-range addresses drop the value but stay in the pair loop.
          state_d = ST_ADDR;
          if (addr_q <= ADDR_WIDE) wr_en_o = 1'b1;
          else                     err_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wr_addr_o   = addr_q;
  assign wr_val_o    = data_i[1:0];
  assign cmd_error_o = err_q;

endmodule

// File: rtl/video_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// video_cfg_ctrl
// OSD-command configuration controller for scanlines, HDMI wide-screen and
// audio volume. Writes land in shadow registers; with VIDEO_CFG_VSYNC_COMMIT_EN
// defined they reach the outputs only at a vsync falling edge or on
// COMMIT_NOW, so a change never tears a frame. Without the macro, writes go
// straight to the outputs, pending is 0 and vs_n is ignored.
// Ports:
//   clk, reset : 32 MHz clock, asynchronous active-high reset
//   cfg        : slave side of video_cfg_ctrl_if (MCU bytes, vs_n, settings,
//                pending, cmd_error)
// -----------------------------------------------------------------------------
module video_cfg_ctrl
  import video_cfg_pkg::*;
#(
  parameter logic [1:0] SCANLINES_RST = 2'd0,
  parameter logic [1:0] VOLUME_RST    = 2'd3,
  parameter logic       WIDE_RST      = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  video_cfg_ctrl_if.slave cfg
);

  localparam video_cfg_t CFG_RST = '{scanlines: SCANLINES_RST,
                                     volume:    VOLUME_RST,
                                     wide:      WIDE_RST};

  logic       wr_en;
  logic [7:0] wr_addr;
  logic [1:0] wr_val;
  logic       commit_now;
  video_cfg_t shadow_q, shadow_d;
  video_cfg_t active;

  video_cfg_parser u_parser (
    .clk         (clk),
    .reset       (reset),
    .start_i     (cfg.mcu_start),
    .strobe_i    (cfg.mcu_strobe),
    .data_i      (cfg.mcu_data),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_val_o    (wr_val),
    .commit_o    (commit_now),
    .cmd_error_o (cfg.cmd_error)
  );

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      case (wr_addr)
        ADDR_SCANLINES: shadow_d.scanlines = wr_val;
        ADDR_VOLUME:    shadow_d.volume    = wr_val;
        ADDR_WIDE:      shadow_d.wide      = wr_val[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow_q <= CFG_RST;
    else       shadow_q <= shadow_d;
  end

`ifdef VIDEO_CFG_VSYNC_COMMIT_EN
  logic       vs_smp_q, vs_hist_q;
  logic       vs_fall, do_commit;
  logic       pending_q, pending_d;
  video_cfg_t active_q, active_d;

  // vs_n is registered once, then edge-detected against its previous sample.
  assign vs_fall   = vs_hist_q & ~vs_smp_q;
  assign do_commit = commit_now | (vs_fall & (pending_q | wr_en));

  // Committing from shadow_d forwards a same-cycle write to the outputs.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    if (wr_en) pending_d = 1'b1;
    if (do_commit) begin
      active_d  = shadow_d;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_smp_q  <= 1'b1;
      vs_hist_q <= 1'b1;
      pending_q <= 1'b0;
      active_q  <= CFG_RST;
    end else begin
      vs_smp_q  <= cfg.vs_n;
      vs_hist_q <= vs_smp_q;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  assign active      = active_q;
  assign cfg.pending = pending_q;
`else
  // Shadow registers drive the outputs directly; COMMIT_NOW has no effect.
  logic unused_commit_inputs;
  assign unused_commit_inputs = cfg.vs_n ^ commit_now;

  assign active      = shadow_q;
  assign cfg.pending = 1'b0;
`endif

  assign cfg.system_scanlines   = active.scanlines;
  assign cfg.system_volume      = active.volume;
  assign cfg.system_wide_screen = active.wide;

endmodule
